// File: rtl/conv_8b_32b_pkg.sv
// rtl/conv_8b_32b_pkg.sv - shared constants and types for the byte-to-word packer
package conv_8b_32b_pkg;

    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int WORD_W = BYTE_W * NBYTES;
    localparam int ACC_W  = WORD_W - BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam int HOLD_W = $clog2(NBYTES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(NBYTES);

    // The final byte never lands in the accumulator; it is spliced in on completion.
    function automatic logic [WORD_W-1:0] join_word(input logic [ACC_W-1:0]  upper,
                                                    input logic [BYTE_W-1:0] last);
        return {upper, last};
    endfunction

endpackage

// File: rtl/conv_8b_32b_if.sv
// rtl/conv_8b_32b_if.sv - byte stream in, held word stream out
interface conv_8b_32b_if;
    import conv_8b_32b_pkg::*;

    logic [BYTE_W-1:0] data_in;
    logic              valid_in;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic              word_strobe;
    logic              err_partial;

    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, word_strobe, err_partial
    );

    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, word_strobe, err_partial
    );

endinterface

// File: rtl/conv_8b_32b.sv
// rtl/conv_8b_32b.sv - packs MSB-first bytes into words held 4 cycles on clk_4f
module conv_8b_32b
    import conv_8b_32b_pkg::*;
(
    input  logic          clk_4f,
    input  logic          reset_L,
    conv_8b_32b_if.slave  bus
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    byte_cnt;
    logic [ACC_W-1:0]    acc;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NBYTES-2:0]   lane_we;
    logic                word_done;
    logic                word_abort;

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.valid_in) state_nxt = ST_FILL;
            ST_FILL: if (!bus.valid_in || byte_cnt == LAST_BYTE) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lane k is written by the k-th byte of a word; IDLE always has byte_cnt=0.
    always_comb begin
        word_done  = (state == ST_FILL) && bus.valid_in && (byte_cnt == LAST_BYTE);
        word_abort = (state == ST_FILL) && !bus.valid_in;
        lane_we    = '0;
        for (int k = 0; k < NBYTES - 1; k++) begin
            lane_we[k] = bus.valid_in && (byte_cnt == CNT_W'(k));
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            byte_cnt <= '0;
        end else if (word_done || word_abort) begin
            byte_cnt <= '0;
        end else if (bus.valid_in) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            acc <= '0;
        end else begin
            for (int k = 0; k < NBYTES - 1; k++) begin
                if (lane_we[k]) begin
                    acc[ACC_W-1-BYTE_W*k -: BYTE_W] <= bus.data_in;
                end
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            hold_cnt <= '0;
        end else if (word_done) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // The word drops on the edge where the hold timer runs out, unless a new one replaces it.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            bus.data_out    <= '0;
            bus.valid_out   <= 1'b0;
            bus.word_strobe <= 1'b0;
            bus.err_partial <= 1'b0;
        end else begin
            bus.word_strobe <= word_done;
            bus.err_partial <= word_abort;
            if (word_done) begin
                bus.data_out  <= join_word(acc, bus.data_in);
                bus.valid_out <= 1'b1;
            end else if (hold_cnt == HOLD_W'(1)) begin
                bus.data_out  <= '0;
                bus.valid_out <= 1'b0;
            end
        end
    end

    a_strobe_err_exclusive: assert property (@(posedge clk_4f) disable iff (!reset_L)
        !(bus.word_strobe && bus.err_partial));

    a_cnt_matches_state: assert property (@(posedge clk_4f) disable iff (!reset_L)
        (byte_cnt == '0) == (state == ST_IDLE));

    a_idle_data_zero: assert property (@(posedge clk_4f) disable iff (!reset_L)
        !bus.valid_out |-> (bus.data_out == '0));

endmodule

// File: tb/tb_conv_8b_32b.sv
// tb/tb_conv_8b_32b.sv - directed and loopback bench for conv_8b_32b
module tb_conv_8b_32b;

    logic clk_4f = 1'b0;
    logic reset_L;
    int   errors = 0;
    int   checks = 0;

    conv_8b_32b_if bus();

    conv_8b_32b dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    function automatic logic [34:0] observed();
        return {bus.valid_out, bus.word_strobe, bus.err_partial, bus.data_out};
    endfunction

    task automatic test_reset();
        logic [34:0] obs;
        reset_L      = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = observed();
            checks++;
            if (obs !== 35'h0)
                $display("FAIL reset[%0d]: got %h expected %h", i, obs, 35'h0);
            if (obs !== 35'h0) errors++;
        end
        reset_L      = 1'b1;
        bus.valid_in = 1'b0;
        tick();
        obs = observed();
        checks++;
        if (obs !== 35'h0) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, 35'h0);
        end
    endtask

    task automatic test_single_word();
        logic [8:0]  stim [9] = '{9'h1DE, 9'h1AD, 9'h1BE, 9'h1EF,
                                 9'h0C3, 9'h0C3, 9'h0C3, 9'h0C3, 9'h0C3};
        logic [34:0] expv [9] = '{35'h0, 35'h0, 35'h0,
                                 {3'b110, 32'hDEADBEEF}, {3'b100, 32'hDEADBEEF},
                                 {3'b100, 32'hDEADBEEF}, {3'b100, 32'hDEADBEEF},
                                 35'h0, 35'h0};
        logic [34:0] obs;
        for (int i = 0; i < 9; i++) begin
            {bus.valid_in, bus.data_in} = stim[i];
            tick();
            obs = observed();
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("FAIL single_word[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  stim [12] = '{9'h101, 9'h123, 9'h145, 9'h167,
                                  9'h189, 9'h1AB, 9'h1CD, 9'h1EF,
                                  9'h05A, 9'h05A, 9'h05A, 9'h05A};
        logic [34:0] expv [12] = '{35'h0, 35'h0, 35'h0,
                                  {3'b110, 32'h01234567}, {3'b100, 32'h01234567},
                                  {3'b100, 32'h01234567}, {3'b100, 32'h01234567},
                                  {3'b110, 32'h89ABCDEF}, {3'b100, 32'h89ABCDEF},
                                  {3'b100, 32'h89ABCDEF}, {3'b100, 32'h89ABCDEF},
                                  35'h0};
        logic [34:0] obs;
        for (int i = 0; i < 12; i++) begin
            {bus.valid_in, bus.data_in} = stim[i];
            tick();
            obs = observed();
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_partial_drop();
        logic [8:0]  stim [11] = '{9'h111, 9'h122, 9'h0FF,
                                  9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD,
                                  9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF};
        logic [34:0] expv [11] = '{35'h0, 35'h0, {3'b001, 32'h0},
                                  35'h0, 35'h0, 35'h0,
                                  {3'b110, 32'hAABBCCDD}, {3'b100, 32'hAABBCCDD},
                                  {3'b100, 32'hAABBCCDD}, {3'b100, 32'hAABBCCDD},
                                  35'h0};
        logic [34:0] obs;
        for (int i = 0; i < 11; i++) begin
            {bus.valid_in, bus.data_in} = stim[i];
            tick();
            obs = observed();
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("FAIL partial_drop[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [9:0]  stim [11] = '{10'h355, 10'h366, 10'h177,
                                  10'h301, 10'h302, 10'h303, 10'h304,
                                  10'h2EE, 10'h2EE, 10'h2EE, 10'h2EE};
        logic [34:0] expv [11] = '{35'h0, 35'h0, 35'h0, 35'h0, 35'h0, 35'h0,
                                  {3'b110, 32'h01020304}, {3'b100, 32'h01020304},
                                  {3'b100, 32'h01020304}, {3'b100, 32'h01020304},
                                  35'h0};
        logic [34:0] obs;
        for (int i = 0; i < 11; i++) begin
            {reset_L, bus.valid_in, bus.data_in} = stim[i];
            tick();
            obs = observed();
            checks++;
            if (obs !== expv[i]) begin
                errors++;
                $display("FAIL reset_mid_word[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    // Serializer model: each word goes out MSB byte first with valid_in held high.
    task automatic test_loopback();
        logic [31:0] words [100];
        logic [34:0] obs;
        logic [34:0] expv;
        for (int w = 0; w < 100; w++) words[w] = $urandom;
        for (int w = 0; w < 100; w++) begin
            for (int b = 0; b < 4; b++) begin
                bus.valid_in = 1'b1;
                bus.data_in  = words[w][31-8*b -: 8];
                tick();
                if (b == 3)      expv = {3'b110, words[w]};
                else if (w == 0) expv = 35'h0;
                else             expv = {3'b100, words[w-1]};
                obs = observed();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL loopback[%0d.%0d]: got %h expected %h", w, b, obs, expv);
                end
            end
        end
        bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expv = (i < 3) ? {3'b100, words[99]} : 35'h0;
            obs  = observed();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL loopback_tail[%0d]: got %h expected %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial_drop();
        test_reset_mid_word();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
